// File: rtl/n64adv_cfg_engine.sv
`default_nettype none
// ============================================================================
// n64adv_cfg_engine : frame-rate config/OSD menu engine for the N64Adv DAC.
// Optional macro OSD_FWVER_EN appends the HDL firmware version at row 15.
// Revision: 1.0
// ============================================================================
module n64adv_cfg_engine #(
  parameter logic [3:0]  GAMMA_DEF = 4'd5,
  parameter logic [15:0] OSD_COMBO = 16'h0C04
) (
  input  logic        clk_clk,
  input  logic        rst_reset_n,
  input  logic [1:0]  sync_in_export,
  input  logic [31:0] ctrl_data_in_export,
  input  logic [7:0]  jumper_cfg_set_in_export,
  input  logic [7:0]  info_set_in_export,
  input  logic [11:0] hdl_fw_in_export,
  output logic [9:0]  vd_wraddr_export,
  output logic [1:0]  vd_wrctrl_export,
  output logic [12:0] vd_wrdata_export,
  output logic [31:0] cfg_set0_out_export,
  output logic [31:0] cfg_set1_out_export
);

`ifdef OSD_FWVER_EN
  localparam logic [4:0] LAST_IDX = 5'd18;
`else
  localparam logic [4:0] LAST_IDX = 5'd15;
`endif

  typedef enum logic [0:0] {SEQ_IDLE = 1'b0, SEQ_RUN = 1'b1} seq_state_t;

  function automatic logic [1:0] clamp2(input logic [1:0] v);
    return (v == 2'd3) ? 2'd2 : v;
  endfunction

  function automatic logic [3:0] item_max(input logic [2:0] idx);
    case (idx)
      3'd1:    return 4'd2;
      3'd2:    return 4'd8;
      3'd5:    return 4'd4;
      3'd7:    return 4'd2;
      default: return 4'd1;
    endcase
  endfunction

  // Eight 4-bit menu item values, item i in bits [4i+3:4i].
  function automatic logic [31:0] pack_items(
    input logic       b15,
    input logic [1:0] deb,
    input logic [3:0] gam,
    input logic       rgsb,
    input logic       ypbpr,
    input logic [2:0] filt,
    input logic       igr,
    input logic [1:0] lm
  );
    return {2'b00, lm, 3'b000, igr, 1'b0, filt, 3'b000, ypbpr,
            3'b000, rgsb, gam, 2'b00, deb, 3'b000, b15};
  endfunction

  function automatic logic [6:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (7'h30 + {3'b000, n}) : (7'h41 + {3'b000, n} - 7'd10);
  endfunction

  logic [1:0]  sync_m_q, sync_m_d, sync_q, sync_d;
  logic        vs_prev_q, vs_prev_d;
  logic        info_prev_q, info_prev_d;
  logic [15:0] prev_btn_q, prev_btn_d;
  logic [2:0]  cursor_q, cursor_d;
  logic [31:0] cfg0_q, cfg0_d, cfg1_q, cfg1_d;
  seq_state_t  seq_state_q, seq_state_d;
  logic [4:0]  seq_idx_q, seq_idx_d;
  logic [9:0]  wraddr_q, wraddr_d;
  logic [1:0]  wrctrl_q, wrctrl_d;
  logic [12:0] wrdata_q, wrdata_d;

  logic [31:0] rst_cfg0, rst_cfg1;
  logic        frame_tick;
  logic [15:0] btn;
  logic [3:0]  new_dir;
  logic [31:0] cur_items, nxt_items;
  logic [3:0]  cur_val, cur_max, new_val;
  logic        emit;
  logic [4:0]  emit_idx;
  logic [2:0]  row;
  logic [3:0]  row_val;
  logic [1:0]  fw_sel;
  logic [3:0]  fw_nib;

  always_comb begin
    rst_cfg0       = '0;
    rst_cfg0[0]    = jumper_cfg_set_in_export[0];
    rst_cfg0[2:1]  = clamp2(jumper_cfg_set_in_export[4:3]);
    rst_cfg0[7:4]  = GAMMA_DEF;
    rst_cfg0[8]    = jumper_cfg_set_in_export[1];
    rst_cfg0[9]    = jumper_cfg_set_in_export[2];
    rst_cfg0[26]   = 1'b1;
    rst_cfg1       = '0;
    rst_cfg1[30:29] = clamp2(jumper_cfg_set_in_export[6:5]);
  end

  // Frame tick handling, menu navigation and fallback override.
  always_comb begin
    sync_m_d    = sync_in_export;
    sync_d      = sync_m_q;
    vs_prev_d   = sync_q[0];
    info_prev_d = info_set_in_export[0];
    frame_tick  = vs_prev_q & ~sync_q[0];
    btn         = ctrl_data_in_export[15:0];
    new_dir     = btn[7:4] & ~prev_btn_q[7:4];
    prev_btn_d  = prev_btn_q;
    cursor_d    = cursor_q;
    cfg0_d      = cfg0_q;
    cfg1_d      = cfg1_q;
    cur_items   = pack_items(cfg0_q[0], cfg0_q[2:1], cfg0_q[7:4], cfg0_q[8],
                             cfg0_q[9], cfg0_q[12:10], cfg0_q[18], cfg1_q[30:29]);
    cur_val     = cur_items[{cursor_q, 2'b00} +: 4];
    cur_max     = item_max(cursor_q);
    new_val     = cur_val;

    if (frame_tick && sync_q[1]) begin
      prev_btn_d = btn;
      if (btn == OSD_COMBO && prev_btn_q != OSD_COMBO) begin
        cfg0_d[25] = ~cfg0_q[25];
      end else if (cfg0_q[25]) begin
        if (new_dir[0]) begin
          cursor_d = cursor_q - 3'd1;
        end else if (new_dir[1]) begin
          cursor_d = cursor_q + 3'd1;
        end else if (new_dir[2]) begin
          if (cur_max == 4'd1)        new_val = {3'b000, ~cur_val[0]};
          else if (cur_val != 4'd0)   new_val = cur_val - 4'd1;
        end else if (new_dir[3]) begin
          if (cur_max == 4'd1)        new_val = {3'b000, ~cur_val[0]};
          else if (cur_val < cur_max) new_val = cur_val + 4'd1;
        end
      end
    end

    case (cursor_q)
      3'd0:    cfg0_d[0]       = new_val[0];
      3'd1:    cfg0_d[2:1]     = new_val[1:0];
      3'd2:    cfg0_d[7:4]     = new_val;
      3'd3:    cfg0_d[8]       = new_val[0];
      3'd4:    cfg0_d[9]       = new_val[0];
      3'd5:    cfg0_d[12:10]   = new_val[2:0];
      3'd6:    cfg0_d[18]      = new_val[0];
      default: cfg1_d[30:29]   = new_val[1:0];
    endcase

    if (info_set_in_export[0] && !info_prev_q) begin
      cfg0_d[0]      = 1'b0;
      cfg0_d[2:1]    = 2'd0;
      cfg0_d[7:4]    = GAMMA_DEF;
      cfg0_d[8]      = 1'b0;
      cfg0_d[9]      = 1'b0;
      cfg0_d[12:10]  = 3'd0;
      cfg0_d[25]     = 1'b1;
      cfg1_d[30:29]  = 2'd0;
    end
  end

  // OSD write sequencer; outputs are registered from next-state values so
  // the first strobe shows the configuration updated by the same tick.
  always_comb begin
    nxt_items = pack_items(cfg0_d[0], cfg0_d[2:1], cfg0_d[7:4], cfg0_d[8],
                           cfg0_d[9], cfg0_d[12:10], cfg0_d[18], cfg1_d[30:29]);
    emit     = 1'b0;
    emit_idx = seq_idx_q;
    if (frame_tick && cfg0_d[25]) begin
      emit     = 1'b1;
      emit_idx = 5'd0;
    end else if (seq_state_q == SEQ_RUN && cfg0_d[25]) begin
      emit = 1'b1;
    end
    seq_state_d = (emit && emit_idx != LAST_IDX) ? SEQ_RUN : SEQ_IDLE;
    seq_idx_d   = emit_idx + 5'd1;

    row      = emit_idx[3:1];
    row_val  = nxt_items[{row, 2'b00} +: 4];
    fw_sel   = emit_idx[1:0];
    fw_nib   = 4'd0;
    wrctrl_d = emit ? 2'b01 : 2'b00;
    wraddr_d = '0;
    wrdata_d = '0;
    if (emit) begin
`ifdef OSD_FWVER_EN
      if (emit_idx[4]) begin
        case (fw_sel)
          2'd0:    fw_nib = hdl_fw_in_export[11:8];
          2'd1:    fw_nib = hdl_fw_in_export[7:4];
          default: fw_nib = hdl_fw_in_export[3:0];
        endcase
        wraddr_d = {5'd15, 5'd29 + {3'b000, fw_sel}};
        wrdata_d = {6'b000000, hex_char(fw_nib)};
      end else
`endif
      if (!emit_idx[0]) begin
        wraddr_d = {2'b00, row, 5'd0};
        wrdata_d = (row == cursor_d) ? {4'b0000, 2'b01, 7'h3E} : {4'b0000, 2'b00, 7'h20};
      end else begin
        wraddr_d = {2'b00, row, 5'd31};
        wrdata_d = {6'b000000, 7'h30 + {3'b000, row_val}};
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!rst_reset_n) begin
      sync_m_q    <= '0;
      sync_q      <= '0;
      vs_prev_q   <= 1'b0;
      info_prev_q <= 1'b0;
      prev_btn_q  <= '0;
      cursor_q    <= '0;
      cfg0_q      <= rst_cfg0;
      cfg1_q      <= rst_cfg1;
      seq_state_q <= SEQ_IDLE;
      seq_idx_q   <= '0;
      wraddr_q    <= '0;
      wrctrl_q    <= '0;
      wrdata_q    <= '0;
    end else begin
      sync_m_q    <= sync_m_d;
      sync_q      <= sync_d;
      vs_prev_q   <= vs_prev_d;
      info_prev_q <= info_prev_d;
      prev_btn_q  <= prev_btn_d;
      cursor_q    <= cursor_d;
      cfg0_q      <= cfg0_d;
      cfg1_q      <= cfg1_d;
      seq_state_q <= seq_state_d;
      seq_idx_q   <= seq_idx_d;
      wraddr_q    <= wraddr_d;
      wrctrl_q    <= wrctrl_d;
      wrdata_q    <= wrdata_d;
    end
  end

  assign vd_wraddr_export    = wraddr_q;
  assign vd_wrctrl_export    = wrctrl_q;
  assign vd_wrdata_export    = wrdata_q;
  assign cfg_set0_out_export = cfg0_q;
  assign cfg_set1_out_export = cfg1_q;

  logic unused_ok;
`ifdef OSD_FWVER_EN
  assign unused_ok = ^{ctrl_data_in_export[31:16], info_set_in_export[7:1],
                       jumper_cfg_set_in_export[7]};
`else
  assign unused_ok = ^{ctrl_data_in_export[31:16], info_set_in_export[7:1],
                       jumper_cfg_set_in_export[7], hdl_fw_in_export, fw_sel, fw_nib};
`endif

endmodule
`default_nettype wire

// File: tb/tb_n64adv_cfg_engine.sv
`default_nettype none
// Testbench for n64adv_cfg_engine: random menu traffic against a field-level
// model; expected OSD writes are queued and checked by an independent monitor.
module tb_n64adv_cfg_engine;

  localparam logic [3:0]  GAMMA_DEF = 4'd5;
  localparam logic [15:0] COMBO     = 16'h0C04;
  localparam logic [15:0] DU = 16'h0010, DD = 16'h0020, DL = 16'h0040, DR = 16'h0080;
`ifdef OSD_FWVER_EN
  localparam int NWR = 19;
`else
  localparam int NWR = 16;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  sync_in = 2'b00;
  logic [31:0] ctrl = '0;
  logic [7:0]  jumper = 8'h5B;
  logic [7:0]  info = '0;
  logic [11:0] hdl_fw = 12'h2A7;
  logic [9:0]  wraddr;
  logic [1:0]  wrctrl;
  logic [12:0] wrdata;
  logic [31:0] cfg0, cfg1;

  always #5 clk = ~clk;

  n64adv_cfg_engine #(.GAMMA_DEF(GAMMA_DEF), .OSD_COMBO(COMBO)) dut (
    .clk_clk                  (clk),
    .rst_reset_n              (rst_n),
    .sync_in_export           (sync_in),
    .ctrl_data_in_export      (ctrl),
    .jumper_cfg_set_in_export (jumper),
    .info_set_in_export       (info),
    .hdl_fw_in_export         (hdl_fw),
    .vd_wraddr_export         (wraddr),
    .vd_wrctrl_export         (wrctrl),
    .vd_wrdata_export         (wrdata),
    .cfg_set0_out_export      (cfg0),
    .cfg_set1_out_export      (cfg1)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [9:0]  addr;
    logic [12:0] data;
  } wr_t;
  wr_t exp_q[$];
  wr_t e;

  // Reference model: plain item values indexed by menu position.
  int item[8];
  int maxv[8] = '{1, 2, 8, 1, 1, 4, 1, 2};
  int show, cursor;
  logic [15:0] prev;
  bit skip_run = 1'b0;
  int run = 0;

  function automatic int clamp2(input int v);
    return (v > 2) ? 2 : v;
  endfunction

  task automatic m_reset(input logic [7:0] j);
    item[0] = j[0];
    item[1] = clamp2(int'(j[4:3]));
    item[2] = GAMMA_DEF;
    item[3] = j[1];
    item[4] = j[2];
    item[5] = 0;
    item[6] = 0;
    item[7] = clamp2(int'(j[6:5]));
    show = 0; cursor = 0; prev = '0;
  endtask

  task automatic m_fallback();
    item[0] = 0; item[1] = 0; item[2] = GAMMA_DEF; item[3] = 0;
    item[4] = 0; item[5] = 0; item[7] = 0; show = 1;
  endtask

  function automatic logic [31:0] m_cfg0();
    return 32'(item[0]) | (32'(item[1]) << 1) | (32'(item[2]) << 4) |
           (32'(item[3]) << 8) | (32'(item[4]) << 9) | (32'(item[5]) << 10) |
           (32'(item[6]) << 18) | (32'(show) << 25) | (32'd1 << 26);
  endfunction

  function automatic logic [31:0] m_cfg1();
    return 32'(item[7]) << 29;
  endfunction

  task automatic m_tick(input logic [15:0] btn, input bit flag);
    logic [15:0] nb;
    if (flag) begin
      nb = btn & ~prev;
      if (btn == COMBO && prev != COMBO) show ^= 1;
      else if (show == 1) begin
        if (nb[4])      cursor = (cursor + 7) % 8;
        else if (nb[5]) cursor = (cursor + 1) % 8;
        else if (nb[6]) begin
          if (maxv[cursor] == 1) item[cursor] ^= 1;
          else if (item[cursor] > 0) item[cursor]--;
        end else if (nb[7]) begin
          if (maxv[cursor] == 1) item[cursor] ^= 1;
          else if (item[cursor] < maxv[cursor]) item[cursor]++;
        end
      end
      prev = btn;
    end
    if (show == 1) begin
      for (int r = 0; r < 8; r++) begin
        exp_q.push_back('{addr: 10'(r * 32),
                          data: (r == cursor) ? 13'({2'b01, 7'h3E}) : 13'(7'h20)});
        exp_q.push_back('{addr: 10'(r * 32 + 31), data: 13'(48 + item[r])});
      end
`ifdef OSD_FWVER_EN
      for (int k = 0; k < 3; k++) begin
        int nib;
        nib = (int'(hdl_fw) >> (8 - 4 * k)) & 15;
        exp_q.push_back('{addr: 10'(15 * 32 + 29 + k),
                          data: 13'((nib < 10) ? (48 + nib) : (65 + nib - 10))});
      end
`endif
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_vec++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  task automatic tick_only(input logic [15:0] btn, input bit flag);
    ctrl    = {16'($urandom), btn};
    sync_in = {flag, 1'b1};
    step(4);
    sync_in = {flag, 1'b0};
    m_tick(btn, flag);
  endtask

  task automatic frame(input logic [15:0] btn, input bit flag);
    tick_only(btn, flag);
    step(30);
    check("cfg_set0", cfg0, m_cfg0());
    check("cfg_set1", cfg1, m_cfg1());
    check("pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset(input logic [7:0] j);
    jumper = j;
    rst_n  = 1'b0;
    step(3);
    exp_q.delete();
    m_reset(j);
    check("rst_cfg_set0", cfg0, m_cfg0());
    check("rst_cfg_set1", cfg1, m_cfg1());
    check("rst_wrctrl", 32'(wrctrl), 32'd0);
    check("rst_wraddr", 32'(wraddr), 32'd0);
    check("rst_wrdata", 32'(wrdata), 32'd0);
    rst_n = 1'b1;
    step(2);
  endtask

  // Monitor: pops one expected write per strobe and checks burst length.
  always @(negedge clk) begin
    if (wrctrl[1] === 1'b1) begin
      n_err++;
      $display("FAIL wrctrl_code got %b required 00/01", wrctrl);
    end
    if (wrctrl == 2'b01) begin
      run++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write got addr %h data %h required none", wraddr, wrdata);
      end else begin
        e = exp_q.pop_front();
        if (e.addr !== wraddr || e.data !== wrdata) begin
          n_err++;
          $display("FAIL osd_write got addr %h data %h required addr %h data %h",
                   wraddr, wrdata, e.addr, e.data);
        end
      end
    end else if (run != 0) begin
      if (!skip_run) begin
        n_vec++;
        if (run != NWR) begin
          n_err++;
          $display("FAIL burst_length got %0d required %0d", run, NWR);
        end
      end
      run = 0;
      skip_run = 1'b0;
    end
  end

  initial begin
    do_reset(8'h5B);

    // Combo toggling: open, hold (no toggle), release, repress (close), reopen.
    frame(COMBO, 1'b1);
    check("show_open", 32'(cfg0[25]), 32'd1);
    frame(COMBO, 1'b1);
    check("show_held", 32'(cfg0[25]), 32'd1);
    frame(16'h0000, 1'b1);
    frame(COMBO, 1'b1);
    check("show_closed", 32'(cfg0[25]), 32'd0);
    frame(DR, 1'b1);
    frame(16'h0000, 1'b1);
    frame(COMBO, 1'b1);

    // Cursor wrap and deblur saturation.
    frame(DU, 1'b1);
    frame(DD, 1'b1);
    frame(16'h0000, 1'b1);
    frame(DD, 1'b1);
    frame(16'h0000, 1'b1);
    frame(DL, 1'b1); frame(16'h0000, 1'b1);
    frame(DL, 1'b1); frame(16'h0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      frame(DR, 1'b1);
      frame(16'h0000, 1'b1);
    end
    check("deblur_sat", 32'(cfg0[2:1]), 32'd2);

    // Gamma down to 2, RGsB on, then fallback.
    frame(DD, 1'b1); frame(16'h0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      frame(DL, 1'b1);
      frame(16'h0000, 1'b1);
    end
    frame(DD, 1'b1); frame(16'h0000, 1'b1);
    if (cfg0[8] == 1'b0) begin
      frame(DR, 1'b1);
      frame(16'h0000, 1'b1);
    end
    info = 8'h01;
    step(3);
    m_fallback();
    check("fallback_cfg0", cfg0, m_cfg0());
    check("fallback_cfg1", cfg1, m_cfg1());
    info = 8'h00;
    step(2);

    // Tick without new-data flag: no config change, refresh still runs.
    frame(DR, 1'b0);
    frame(COMBO, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [15:0] b;
      case ($urandom_range(0, 7))
        0:       b = DU;
        1:       b = DD;
        2:       b = DL;
        3:       b = DR;
        4:       b = COMBO;
        5:       b = 16'($urandom);
        default: b = 16'h0000;
      endcase
      frame(b, ($urandom_range(0, 9) != 0));
    end

    // Reset asserted in the middle of a refresh burst.
    if (show == 0) begin
      frame(16'h0000, 1'b1);
      frame(COMBO, 1'b1);
    end
    tick_only(16'h0000, 1'b1);
    step(8);
    skip_run = 1'b1;
    rst_n = 1'b0;
    step(1);
    exp_q.delete();
    m_reset(jumper);
    check("abort_wrctrl", 32'(wrctrl), 32'd0);
    check("abort_cfg0", cfg0, m_cfg0());
    check("abort_cfg1", cfg1, m_cfg1());
    step(2);
    rst_n = 1'b1;
    step(2);

    do_reset(8'h7F);
    frame(COMBO, 1'b1);
    frame(16'h0000, 1'b1);
    frame(DU, 1'b1);
    frame(DL, 1'b1);

    step(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
